read_channel_scan_ctrl: RTL and testbench
=========================================

Name: read_channel_scan_ctrl

Overview:
- Sequences the 64-channel read-register shifter: walks an enable mask and builds a one-hot 64-bit channel select for each enabled channel.
- For each channel it pulses the shifter start, waits for shift completion, then holds the channel for a programmable dwell.
- Sits between slow-control configuration registers and the read-register shifter on the ECAL DIF.
- Supports single-pass and continuous scanning, plus a shift-completion timeout.

Parameters:
- SHIFT_TIMEOUT, 1024, max clock cycles to wait for In_Shift_Done after a start pulse.
- DWELL_WIDTH, 16, width of the dwell-count input.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- In_Scan_Start  input  1  one-cycle start pulse; ignored while Out_Busy=1.
- In_Scan_Stop  input  1  one-cycle stop request.
- In_Continuous  input  1  1=wrap from channel 64 to channel 1 and keep scanning; sampled at start.
- In_Channel_Mask  input  64 [64:1]  1=channel included; latched at start.
- In_Dwell_Cycles  input  DWELL_WIDTH  dwell length after shift completes; latched at start; 0 treated as 1.
- In_Shift_Done  input  1  one-cycle pulse from the shifter when all 64 bits are sent.
- Out_Enable_Register  output  1  shifter enable.
- Out_Choose_Channel  output  64 [64:1]  one-hot channel select to the shifter.
- Out_Start_Set_Register  output  1  one-cycle start pulse to the shifter.
- Out_Current_Channel  output  7  selected channel number 1..64; 0 when none.
- Out_Channel_Valid  output  1  high during dwell; selected channel is active in the ASIC.
- Out_Busy  output  1  high in every state except IDLE.
- Out_Scan_Done  output  1  one-cycle pulse at normal end of scan or stop.
- Out_Timeout_Err  output  1  sticky error; cleared by the next accepted In_Scan_Start.

Behaviour:
- Reset: all outputs 0, state IDLE, latched mask/dwell/continuous cleared. Reset asserted mid-scan aborts immediately to these values.
- All outputs are registered.
- States: IDLE, SEARCH, LOAD, WAIT_SHIFT, DWELL, NEXT.
- IDLE: on In_Scan_Start, latch mask, dwell and continuous; clear Out_Timeout_Err; set index=1; go to SEARCH. Out_Busy and Out_Enable_Register go high the cycle after the start pulse.
- SEARCH:
  - Examines one channel per cycle at the current index.
  - If the mask bit is set: register Out_Choose_Channel=one-hot(index) and Out_Current_Channel=index, then go to LOAD.
  - Otherwise increment the index.
  - Index passing 64 with no hit in this pass: go to IDLE and pulse Out_Scan_Done. An all-zero mask never pulses the shifter.
- LOAD: Out_Start_Set_Register high for exactly one cycle; go to WAIT_SHIFT. Out_Choose_Channel is stable at least 1 cycle before and throughout the pulse.
- WAIT_SHIFT:
  - Count cycles; on In_Shift_Done go to DWELL.
  - If the count reaches SHIFT_TIMEOUT without In_Shift_Done: set Out_Timeout_Err, clear selection outputs, go to IDLE. No Out_Scan_Done pulse is issued.
- DWELL: Out_Channel_Valid=1 for max(In_Dwell_Cycles,1) cycles, then go to NEXT.
- NEXT:
  - Index<64: index+1, go to SEARCH.
  - Index=64 and continuous: index=1, go to SEARCH.
  - Index=64 and not continuous: go to IDLE and pulse Out_Scan_Done.
- Stop:
  - In_Scan_Stop is latched in any non-IDLE state.
  - It is honoured only in SEARCH or NEXT, so an in-flight shift is never aborted. DWELL is shortened to 1 cycle when stop is pending.
  - Honouring stop: go to IDLE, pulse Out_Scan_Done, clear the stop latch.
- Simultaneous In_Scan_Start and In_Scan_Stop in IDLE: start wins; the stop is discarded.
- In_Scan_Start while busy: ignored.
- In_Shift_Done outside WAIT_SHIFT: ignored.
- On entry to IDLE: Out_Choose_Channel=0, Out_Current_Channel=0, Out_Enable_Register=0, Out_Channel_Valid=0.
- Mask or dwell changes during a scan have no effect until the next start.

Test Plan:
- Mask=0x...0005 (channels 1,3), dwell=4, single, shifter model returns done 200 cycles after start. Expect two start pulses with Out_Choose_Channel bit1 then bit3, 4-cycle Out_Channel_Valid windows, one Out_Scan_Done, then Out_Busy=0.
- Mask all zero, start. Expect no Out_Start_Set_Register, Out_Scan_Done about 65 cycles after start, Out_Timeout_Err=0.
- Mask bit64 only, continuous=1. Expect channel 64 selected repeatedly; stop asserted during WAIT_SHIFT completes that shift, then a 1-cycle dwell, IDLE and one Out_Scan_Done.
- Shifter model never returns done, SHIFT_TIMEOUT=1024. Expect Out_Timeout_Err=1 at 1024 cycles after the start pulse and return to IDLE; the next start clears it.
- Rst asserted during DWELL of channel 3. Expect all outputs 0 asynchronously; a subsequent start rescans from channel 1.
- Dwell=0 with start held during busy. Expect 1-cycle valid windows and extra starts ignored (exactly one Out_Scan_Done).

Source files
------------

// File: rtl/read_channel_scan_ctrl.sv
// Read-register channel scan controller: walks a 64-channel enable mask,
// loads a one-hot select into the shifter, waits for it, then dwells.
module read_channel_scan_ctrl #(
    parameter int SHIFT_TIMEOUT = 1024,
    parameter int DWELL_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   In_Scan_Start,
    input  logic                   In_Scan_Stop,
    input  logic                   In_Continuous,
    input  logic [64:1]            In_Channel_Mask,
    input  logic [DWELL_WIDTH-1:0] In_Dwell_Cycles,
    input  logic                   In_Shift_Done,
    output logic                   Out_Enable_Register,
    output logic [64:1]            Out_Choose_Channel,
    output logic                   Out_Start_Set_Register,
    output logic [6:0]             Out_Current_Channel,
    output logic                   Out_Channel_Valid,
    output logic                   Out_Busy,
    output logic                   Out_Scan_Done,
    output logic                   Out_Timeout_Err
);

    localparam int CNT_W = $clog2(SHIFT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        LOAD,
        WAIT_SHIFT,
        DWELL,
        NEXT
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             idx_q, idx_d;
    logic [64:1]            mask_q, mask_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0]       tcnt_q, tcnt_d;
    logic                   cont_q, cont_d;
    logic                   stop_q, stop_d;
    logic [64:1]            choose_q, choose_d;
    logic [6:0]             cur_q, cur_d;
    logic                   en_q, en_d;
    logic                   start_q, start_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   stop_pend;
    logic                   go_idle;
    logic                   hit;
    logic [64:1]            onehot;
    logic [DWELL_WIDTH-1:0] dwell_eff;

    // A stop request arriving this cycle counts as already pending.
    assign stop_pend = stop_q | In_Scan_Stop;
    assign onehot    = 64'd1 << (idx_q - 7'd1);
    assign hit       = |(mask_q & onehot);
    assign dwell_eff = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;

    // Next-state and registered-output computation for the scan sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        dcnt_d   = dcnt_q;
        tcnt_d   = tcnt_q;
        cont_d   = cont_q;
        stop_d   = stop_q;
        choose_d = choose_q;
        cur_d    = cur_q;
        en_d     = en_q;
        start_d  = 1'b0;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        go_idle  = 1'b0;

        if (state_q != IDLE) begin
            stop_d = stop_pend;
        end

        unique case (state_q)
            IDLE: begin
                if (In_Scan_Start) begin
                    mask_d  = In_Channel_Mask;
                    dwell_d = In_Dwell_Cycles;
                    cont_d  = In_Continuous;
                    err_d   = 1'b0;
                    stop_d  = 1'b0;
                    idx_d   = 7'd1;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (stop_pend) begin
                    go_idle = 1'b1;
                    done_d  = 1'b1;
                end else if (hit) begin
                    choose_d = onehot;
                    cur_d    = idx_q;
                    state_d  = LOAD;
                end else if (idx_q == 7'd64) begin
                    go_idle = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            LOAD: begin
                start_d = 1'b1;
                tcnt_d  = '0;
                state_d = WAIT_SHIFT;
            end
            WAIT_SHIFT: begin
                if (In_Shift_Done) begin
                    valid_d = 1'b1;
                    dcnt_d  = DWELL_WIDTH'(1);
                    state_d = DWELL;
                end else if (tcnt_q == CNT_W'(SHIFT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    go_idle = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            DWELL: begin
                if (stop_pend || (dcnt_q >= dwell_eff)) begin
                    valid_d = 1'b0;
                    state_d = NEXT;
                end else begin
                    dcnt_d = dcnt_q + DWELL_WIDTH'(1);
                end
            end
            NEXT: begin
                if (stop_pend) begin
                    go_idle = 1'b1;
                    done_d  = 1'b1;
                end else if (idx_q != 7'd64) begin
                    idx_d   = idx_q + 7'd1;
                    state_d = SEARCH;
                end else if (cont_q) begin
                    idx_d   = 7'd1;
                    state_d = SEARCH;
                end else begin
                    go_idle = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_idle) begin
            state_d  = IDLE;
            choose_d = '0;
            cur_d    = '0;
            en_d     = 1'b0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            stop_d   = 1'b0;
        end
    end

    // State and output registers; reset aborts any scan immediately.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
            dcnt_q   <= '0;
            tcnt_q   <= '0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
            choose_q <= '0;
            cur_q    <= '0;
            en_q     <= 1'b0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            dcnt_q   <= dcnt_d;
            tcnt_q   <= tcnt_d;
            cont_q   <= cont_d;
            stop_q   <= stop_d;
            choose_q <= choose_d;
            cur_q    <= cur_d;
            en_q     <= en_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Out_Enable_Register    = en_q;
    assign Out_Choose_Channel     = choose_q;
    assign Out_Start_Set_Register = start_q;
    assign Out_Current_Channel    = cur_q;
    assign Out_Channel_Valid      = valid_q;
    assign Out_Busy               = busy_q;
    assign Out_Scan_Done          = done_q;
    assign Out_Timeout_Err        = err_q;

endmodule

// File: tb/tb_read_channel_scan_ctrl.sv
// Bench for read_channel_scan_ctrl: randomized and directed scans compared
// against a transaction-level model of the expected channel sequence.
module tb_read_channel_scan_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_Scan_Start = 1'b0;
    logic        In_Scan_Stop = 1'b0;
    logic        In_Continuous = 1'b0;
    logic [64:1] In_Channel_Mask = '0;
    logic [15:0] In_Dwell_Cycles = '0;
    logic        In_Shift_Done = 1'b0;
    logic        Out_Enable_Register;
    logic [64:1] Out_Choose_Channel;
    logic        Out_Start_Set_Register;
    logic [6:0]  Out_Current_Channel;
    logic        Out_Channel_Valid;
    logic        Out_Busy;
    logic        Out_Scan_Done;
    logic        Out_Timeout_Err;

    read_channel_scan_ctrl #(
        .SHIFT_TIMEOUT(1024),
        .DWELL_WIDTH  (16)
    ) dut (
        .Clk                   (Clk),
        .Rst                   (Rst),
        .In_Scan_Start         (In_Scan_Start),
        .In_Scan_Stop          (In_Scan_Stop),
        .In_Continuous         (In_Continuous),
        .In_Channel_Mask       (In_Channel_Mask),
        .In_Dwell_Cycles       (In_Dwell_Cycles),
        .In_Shift_Done         (In_Shift_Done),
        .Out_Enable_Register   (Out_Enable_Register),
        .Out_Choose_Channel    (Out_Choose_Channel),
        .Out_Start_Set_Register(Out_Start_Set_Register),
        .Out_Current_Channel   (Out_Current_Channel),
        .Out_Channel_Valid     (Out_Channel_Valid),
        .Out_Busy              (Out_Busy),
        .Out_Scan_Done         (Out_Scan_Done),
        .Out_Timeout_Err       (Out_Timeout_Err)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Shifter model: answers each start pulse after lat cycles, or never
    // when dead; optionally injects stray done pulses while idle.
    int lat = 5;
    bit shift_dead = 0;
    bit spur = 0;
    int cd = 0;
    initial begin
        forever begin
            @(negedge Clk);
            In_Shift_Done = 1'b0;
            if (Rst) begin
                cd = 0;
            end else if (Out_Start_Set_Register) begin
                cd = shift_dead ? 0 : lat;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) In_Shift_Done = 1'b1;
            end else if (!shift_dead && spur && $urandom_range(7) == 0) begin
                In_Shift_Done = 1'b1;
            end
        end
    end

    // Monitor: records selected channels, valid windows and done pulses.
    int ch_q[$];
    int win_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int err_cyc = 0;
    int run = 0;
    logic err_prev = 1'b0;
    logic [63:0] prev_sel = '0;
    initial begin
        forever begin
            @(negedge Clk);
            if (Rst) begin
                run = 0;
                prev_sel = '0;
                err_prev = 1'b0;
            end else begin
                if (Out_Start_Set_Register) begin
                    chk("sel_stable", Out_Choose_Channel, prev_sel);
                    chk("sel_onehot", Out_Choose_Channel,
                        64'd1 << (Out_Current_Channel - 7'd1));
                    ch_q.push_back(int'(Out_Current_Channel));
                    start_cyc = cyc;
                end
                if (Out_Channel_Valid) begin
                    run++;
                end else if (run > 0) begin
                    win_q.push_back(run);
                    run = 0;
                end
                if (Out_Scan_Done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (Out_Timeout_Err && !err_prev) err_cyc = cyc;
                err_prev = Out_Timeout_Err;
                prev_sel = Out_Choose_Channel;
            end
        end
    end

    task automatic clear_mon();
        ch_q.delete();
        win_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [63:0] m, input logic [15:0] d,
                               input bit c);
        @(negedge Clk);
        clear_mon();
        In_Channel_Mask = m;
        In_Dwell_Cycles = d;
        In_Continuous = c;
        In_Scan_Start = 1'b1;
        @(negedge Clk);
        In_Scan_Start = 1'b0;
    endtask

    // One single-pass scan compared against the channel list derived from m.
    task automatic run_scan(input logic [63:0] m, input logic [15:0] d,
                            input int l, input bit hold, input bit ss);
        int t0;
        int n;
        int w;
        int exp_ch[$];
        lat = l;
        @(negedge Clk);
        clear_mon();
        In_Channel_Mask = m;
        In_Dwell_Cycles = d;
        In_Continuous = 1'b0;
        In_Scan_Start = 1'b1;
        In_Scan_Stop = ss;
        t0 = cyc;
        @(negedge Clk);
        In_Scan_Stop = 1'b0;
        if (!hold) In_Scan_Start = 1'b0;
        chk("busy_up", {Out_Busy, Out_Enable_Register, Out_Timeout_Err},
            3'b110);
        In_Channel_Mask = {$urandom, $urandom};
        In_Dwell_Cycles = 16'($urandom_range(20, 40));
        In_Continuous = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Out_Scan_Done && n < 20000);
        In_Scan_Start = 1'b0;
        In_Continuous = 1'b0;
        chk("scan_end", n < 20000, 1);
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 64; i++) if (m[i]) exp_ch.push_back(i + 1);
        w = (d == 0) ? 1 : int'(d);
        chk("n_starts", ch_q.size(), exp_ch.size());
        foreach (exp_ch[i])
            if (i < ch_q.size()) chk("chan", ch_q[i], exp_ch[i]);
        chk("n_windows", win_q.size(), exp_ch.size());
        foreach (win_q[i]) chk("dwell", win_q[i], w);
        chk("done_cnt", done_cnt, 1);
        chk("idle_flags", {Out_Busy, Out_Enable_Register, Out_Channel_Valid},
            0);
        chk("sel_clr", Out_Choose_Channel, 0);
        chk("cur_clr", Out_Current_Channel, 0);
        chk("no_err", Out_Timeout_Err, 0);
        if (m == 0) chk("zero_lat", done_cyc - t0, 65);
    endtask

    initial begin
        logic [63:0] m;
        int n;
        int k3;

        repeat (3) @(negedge Clk);
        chk("rst_flags", {Out_Enable_Register, Out_Start_Set_Register,
            Out_Channel_Valid, Out_Busy, Out_Scan_Done, Out_Timeout_Err,
            Out_Current_Channel}, 0);
        chk("rst_sel", Out_Choose_Channel, 0);
        @(negedge Clk);
        Rst = 1'b0;

        // channels 1 and 3, dwell 4, slow shifter, stop alongside start
        run_scan(64'h5, 16'd4, 200, 0, 1);
        // empty mask: no shifter activity, done after a full pass
        run_scan(64'h0, 16'd3, 5, 0, 0);

        spur = 1;
        for (int k = 0; k < 6; k++) begin
            m = {$urandom, $urandom} & {$urandom, $urandom}
                & {$urandom, $urandom};
            if (k == 0) m[63] = 1'b1;
            run_scan(m, 16'($urandom_range(0, 4)), $urandom_range(1, 15),
                     0, k[0]);
        end

        // dwell 0 with start held high for the whole scan
        run_scan(64'h8000_0100_0000_0013, 16'd0, 3, 1, 0);

        // continuous on channel 64, stop during the third shift
        spur = 0;
        lat = 30;
        pulse_start(64'h8000_0000_0000_0000, 16'd3, 1);
        n = 0;
        k3 = 0;
        while (k3 < 3 && n < 3000) begin
            @(negedge Clk);
            n++;
            if (Out_Start_Set_Register) k3++;
        end
        chk("cont_third", k3, 3);
        In_Scan_Stop = 1'b1;
        @(negedge Clk);
        In_Scan_Stop = 1'b0;
        n = 0;
        while (!Out_Scan_Done && n < 500) begin
            @(negedge Clk);
            n++;
        end
        repeat (3) @(negedge Clk);
        chk("stop_starts", ch_q.size(), 3);
        foreach (ch_q[i]) chk("stop_chan", ch_q[i], 64);
        chk("stop_wins", win_q.size(), 3);
        if (win_q.size() == 3) begin
            chk("stop_w0", win_q[0], 3);
            chk("stop_w1", win_q[1], 3);
            chk("stop_w2", win_q[2], 1);
        end
        chk("stop_done", done_cnt, 1);
        chk("stop_busy", Out_Busy, 0);

        // dead shifter: timeout after 1024 cycles, sticky until next start
        shift_dead = 1;
        pulse_start(64'h42, 16'd1, 0);
        n = 0;
        while (!Out_Timeout_Err && n < 1500) begin
            @(negedge Clk);
            n++;
        end
        repeat (5) @(negedge Clk);
        chk("to_err", Out_Timeout_Err, 1);
        chk("to_lat", err_cyc - start_cyc, 1024);
        chk("to_busy", Out_Busy, 0);
        chk("to_sel", Out_Choose_Channel, 0);
        chk("to_nodone", done_cnt, 0);
        chk("to_starts", ch_q.size(), 1);
        if (ch_q.size() > 0) chk("to_chan", ch_q[0], 2);
        shift_dead = 0;
        run_scan(64'h24, 16'd2, 4, 0, 0);

        // reset during the dwell of channel 3
        lat = 5;
        pulse_start(64'h15, 16'd10, 0);
        n = 0;
        while (!(Out_Channel_Valid && Out_Current_Channel == 7'd3)
               && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_ch3", n < 2000, 1);
        #2 Rst = 1'b1;
        #1;
        chk("arst_flags", {Out_Enable_Register, Out_Start_Set_Register,
            Out_Channel_Valid, Out_Busy, Out_Scan_Done, Out_Timeout_Err,
            Out_Current_Channel}, 0);
        chk("arst_sel", Out_Choose_Channel, 0);
        @(negedge Clk);
        Rst = 1'b0;
        run_scan(64'h5, 16'd2, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
